// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus sequencer: command codes,
// client indices, FSM state encodings and the round-robin helper.
package lcd_pkg;

    localparam int unsigned N_CLIENTS = 3;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned WAIT_W    = 16;

    localparam logic [7:0] LCD_FUNC_SET = 8'h3C;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE0    = 8'h80;
    localparam logic [7:0] LCD_LINE1    = 8'hC0;

    localparam logic [IDX_W-1:0] WATCH     = 2'd0;
    localparam logic [IDX_W-1:0] ALARM     = 2'd1;
    localparam logic [IDX_W-1:0] STOPWATCH = 2'd2;

    typedef enum logic [3:0] {
        ST_POWER_WAIT,
        ST_INIT_FUNC,
        ST_INIT_DISP,
        ST_INIT_CLR,
        ST_INIT_ENTRY,
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } lcd_state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_EHIGH,
        PH_HOLD,
        PH_SETTLE
    } bus_phase_t;

    // Cyclic successor WATCH -> ALARM -> STOPWATCH -> WATCH.
    function automatic logic [IDX_W-1:0] next_client(input logic [IDX_W-1:0] idx);
        return (idx == STOPWATCH) ? WATCH : IDX_W'(idx + IDX_W'(1));
    endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One LCD bus transaction: setup, E_HIGH strobe cycles, hold, then settle wait.
// finish_c is high in the final settle cycle so the next start can follow back-to-back.
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int unsigned E_HIGH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rs,
    input  logic [7:0]        data,
    input  logic [WAIT_W-1:0] wait_cycles,
    output logic              lcd_e,
    output logic              lcd_rs,
    output logic [7:0]        lcd_data,
    output logic              finish_c
);

    bus_phase_t        phase;
    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] settle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= PH_IDLE;
            cnt      <= '0;
            settle   <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
        end else if (start) begin
            phase    <= PH_SETUP;
            lcd_e    <= 1'b0;
            lcd_rs   <= rs;
            lcd_data <= data;
            settle   <= wait_cycles;
        end else begin
            case (phase)
                PH_SETUP: begin
                    lcd_e <= 1'b1;
                    cnt   <= WAIT_W'(E_HIGH - 1);
                    phase <= PH_EHIGH;
                end
                PH_EHIGH: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b0;
                        phase <= PH_HOLD;
                    end else begin
                        cnt <= cnt - WAIT_W'(1);
                    end
                end
                PH_HOLD: begin
                    if (settle == '0) begin
                        phase <= PH_IDLE;
                    end else begin
                        cnt   <= settle - WAIT_W'(1);
                        phase <= PH_SETTLE;
                    end
                end
                PH_SETTLE: begin
                    if (cnt == '0) begin
                        phase <= PH_IDLE;
                    end else begin
                        cnt <= cnt - WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign finish_c = ((phase == PH_HOLD) && (settle == '0)) ||
                      ((phase == PH_SETTLE) && (cnt == '0));

endmodule

// File: rtl/lcd_bus_arbiter.sv
// LCD bus sequencer: runs the power-on command sequence, then serves
// single-character writes from three clients in round-robin order.
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned PWR_WAIT  = 70,
    parameter int unsigned E_HIGH    = 2,
    parameter int unsigned CMD_WAIT  = 30,
    parameter int unsigned CLR_WAIT  = 100,
    parameter int unsigned DATA_WAIT = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  wr_line,
    input  logic [11:0] wr_col,
    input  logic [23:0] wr_char,
    output logic [2:0]  done,
    output logic        ready,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_data
);

    lcd_state_t        state;
    logic [WAIT_W-1:0] pwr_cnt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  winner;
    logic [7:0]        char_q;

    logic              grant_c;
    logic [IDX_W-1:0]  grant_idx_c;
    logic [IDX_W-1:0]  cand1_c;
    logic [IDX_W-1:0]  cand2_c;
    logic [7:0]        addr_cmd_c;
    logic [7:0]        grant_char_c;

    logic              bus_start_c;
    logic              bus_rs_c;
    logic [7:0]        bus_data_c;
    logic [WAIT_W-1:0] bus_wait_c;
    logic              bus_finish_c;

    assign lcd_rw = 1'b0;

    // Round-robin pick: first asserted request at or after the pointer.
    always_comb begin
        cand1_c     = next_client(rr_ptr);
        cand2_c     = next_client(cand1_c);
        grant_c     = |req;
        grant_idx_c = rr_ptr;
        if (req[rr_ptr]) begin
            grant_idx_c = rr_ptr;
        end else if (req[cand1_c]) begin
            grant_idx_c = cand1_c;
        end else begin
            grant_idx_c = cand2_c;
        end
        addr_cmd_c   = (wr_line[grant_idx_c] ? LCD_LINE1 : LCD_LINE0) |
                       {4'h0, wr_col[{grant_idx_c, 2'b00} +: 4]};
        grant_char_c = wr_char[{grant_idx_c, 3'b000} +: 8];
    end

    // Launch the next transaction in the cycle the current state hands over,
    // so its setup cycle coincides with the first cycle of the next state.
    always_comb begin
        bus_start_c = 1'b0;
        bus_rs_c    = 1'b0;
        bus_data_c  = LCD_FUNC_SET;
        bus_wait_c  = WAIT_W'(CMD_WAIT);
        case (state)
            ST_POWER_WAIT: begin
                bus_start_c = (pwr_cnt == WAIT_W'(PWR_WAIT - 1));
            end
            ST_INIT_FUNC: begin
                bus_start_c = bus_finish_c;
                bus_data_c  = LCD_DISP_ON;
            end
            ST_INIT_DISP: begin
                bus_start_c = bus_finish_c;
                bus_data_c  = LCD_CLEAR;
                bus_wait_c  = WAIT_W'(CLR_WAIT);
            end
            ST_INIT_CLR: begin
                bus_start_c = bus_finish_c;
                bus_data_c  = LCD_ENTRY;
            end
            ST_IDLE: begin
                bus_start_c = grant_c;
                bus_data_c  = addr_cmd_c;
            end
            ST_ADDR: begin
                bus_start_c = bus_finish_c;
                bus_rs_c    = 1'b1;
                bus_data_c  = char_q;
                bus_wait_c  = WAIT_W'(DATA_WAIT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_POWER_WAIT;
            pwr_cnt <= '0;
            rr_ptr  <= WATCH;
            winner  <= WATCH;
            char_q  <= '0;
            done    <= '0;
            ready   <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                ST_POWER_WAIT: begin
                    pwr_cnt <= pwr_cnt + WAIT_W'(1);
                    if (bus_start_c) state <= ST_INIT_FUNC;
                end
                ST_INIT_FUNC:  if (bus_finish_c) state <= ST_INIT_DISP;
                ST_INIT_DISP:  if (bus_finish_c) state <= ST_INIT_CLR;
                ST_INIT_CLR:   if (bus_finish_c) state <= ST_INIT_ENTRY;
                ST_INIT_ENTRY: begin
                    if (bus_finish_c) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (grant_c) begin
                        winner <= grant_idx_c;
                        char_q <= grant_char_c;
                        rr_ptr <= next_client(grant_idx_c);
                        state  <= ST_ADDR;
                    end
                end
                ST_ADDR: if (bus_finish_c) state <= ST_DATA;
                ST_DATA: begin
                    if (bus_finish_c) begin
                        done[winner] <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_POWER_WAIT;
            endcase
        end
    end

    lcd_bus_cycle #(
        .E_HIGH (E_HIGH)
    ) u_bus (
        .clk         (clk),
        .rst         (rst),
        .start       (bus_start_c),
        .rs          (bus_rs_c),
        .data        (bus_data_c),
        .wait_cycles (bus_wait_c),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs),
        .lcd_data    (lcd_data),
        .finish_c    (bus_finish_c)
    );

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: init sequence, single writes,
// round-robin order, field latching and mid-transaction reset.
module tb_lcd_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  wr_line = '0;
    logic [11:0] wr_col = '0;
    logic [23:0] wr_char = '0;
    logic [2:0]  done;
    logic        ready;
    logic        lcd_e;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e_rises = 0;
    int done_pulses = 0;
    logic e_prev = 1'b0;

    lcd_bus_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wr_line  (wr_line),
        .wr_col   (wr_col),
        .wr_char  (wr_char),
        .done     (done),
        .ready    (ready),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_data (lcd_data)
    );

    always #5 clk = ~clk;

    // Cycle number since reset release; cycle 1 starts at release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 1;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            e_prev  <= 1'b0;
            e_rises <= 0;
        end else begin
            if (lcd_e && !e_prev) e_rises <= e_rises + 1;
            e_prev <= lcd_e;
        end
    end

    always @(negedge clk) begin
        if (done != 3'b000) done_pulses <= done_pulses + 1;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic goto(input int n);
        int g = 0;
        while (cyc != n && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != n) begin
            total++;
            bad++;
            $error("FAIL timeout: cycle=%0d expected=%0d", cyc, n);
        end
    endtask

    initial begin
        logic [7:0] exp_addr [3];
        logic [7:0] exp_char [3];
        logic [7:0] exp_done [3];
        int base;
        exp_addr = '{8'h80, 8'hC1, 8'h8F};
        exp_char = '{8'h30, 8'h31, 8'h32};
        exp_done = '{8'h01, 8'h02, 8'h04};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_e", 8'(lcd_e), 8'h00);
        chk("rst_rs", 8'(lcd_rs), 8'h00);
        chk("rst_rw", 8'(lcd_rw), 8'h00);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_done", 8'(done), 8'h00);
        chk("rst_ready", 8'(ready), 8'h00);
        rst = 1'b0;

        // Early request from client 0, must wait for ready
        goto(10);
        req = 3'b001;
        wr_line[0] = 1'b0; wr_col[3:0] = 4'h3; wr_char[7:0] = 8'h5A;

        goto(70);  chk("pwr_e", 8'(lcd_e), 8'h00); chk("pwr_data", lcd_data, 8'h00);
        goto(71);  chk("func_setup", lcd_data, 8'h3C); chk("func_setup_e", 8'(lcd_e), 8'h00);
        goto(72);  chk("func_e", 8'(lcd_e), 8'h01); chk("func_rs", 8'(lcd_rs), 8'h00);
        goto(74);  chk("func_hold_e", 8'(lcd_e), 8'h00); chk("func_hold_data", lcd_data, 8'h3C);
        goto(106); chk("disp_e", 8'(lcd_e), 8'h01); chk("disp_data", lcd_data, 8'h0C);
        goto(140); chk("clr_e", 8'(lcd_e), 8'h01); chk("clr_data", lcd_data, 8'h01);
        goto(244); chk("entry_e", 8'(lcd_e), 8'h01); chk("entry_data", lcd_data, 8'h06);
        chk("entry_rs", 8'(lcd_rs), 8'h00);
        goto(276); chk("ready_276", 8'(ready), 8'h00);
        goto(277); chk("ready_277", 8'(ready), 8'h01); chk("init_pulses", 8'(e_rises), 8'd4);

        // Client 0 served at T=277
        goto(278); chk("c0_addr", lcd_data, 8'h83); chk("c0_addr_rs", 8'(lcd_rs), 8'h00);
        chk("c0_addr_e", 8'(lcd_e), 8'h00);
        goto(279); chk("c0_addr_ehi", 8'(lcd_e), 8'h01);
        goto(312); chk("c0_char", lcd_data, 8'h5A); chk("c0_char_rs", 8'(lcd_rs), 8'h01);
        goto(345); chk("c0_done_early", 8'(done), 8'h00);
        goto(346); chk("c0_done", 8'(done), 8'h01);

        // Client 1: line 1, col 5, 'A'; T=347
        req = 3'b010;
        wr_line[1] = 1'b1; wr_col[7:4] = 4'h5; wr_char[15:8] = 8'h41;
        goto(348); chk("c1_addr", lcd_data, 8'hC5); chk("c1_addr_rs", 8'(lcd_rs), 8'h00);
        goto(349); chk("c1_addr_ehi", 8'(lcd_e), 8'h01);
        goto(382); chk("c1_char", lcd_data, 8'h41); chk("c1_char_rs", 8'(lcd_rs), 8'h01);
        goto(383); chk("c1_char_ehi", 8'(lcd_e), 8'h01);
        goto(415); chk("c1_done_early", 8'(done), 8'h00); chk("c1_hold_data", lcd_data, 8'h41);
        goto(416); chk("c1_done", 8'(done), 8'h02);

        // Client 2 drops req and changes char right after arbitration; T=417
        req = 3'b100;
        wr_line[2] = 1'b1; wr_col[11:8] = 4'hA; wr_char[23:16] = 8'h37;
        goto(418); chk("c2_addr", lcd_data, 8'hCA);
        req = 3'b000; wr_char[23:16] = 8'h38;
        goto(452); chk("c2_char_latched", lcd_data, 8'h37);
        goto(486); chk("c2_done", 8'(done), 8'h04);

        // All three continuously requesting, pointer at 0; T0=487
        req = 3'b111;
        wr_line = 3'b010;
        wr_col  = {4'hF, 4'h1, 4'h0};
        wr_char = {8'h32, 8'h31, 8'h30};
        for (int i = 0; i < 5; i++) begin
            base = 487 + 70 * i;
            goto(base + 1);  chk("rr_addr", lcd_data, exp_addr[i % 3]);
            goto(base + 35); chk("rr_char", lcd_data, exp_char[i % 3]);
            goto(base + 69); chk("rr_done", 8'(done), exp_done[i % 3]);
        end
        req = 3'b000;

        // Reset during lcd_e-high of a DATA write; T=840
        goto(840);
        req = 3'b001; wr_line[0] = 1'b0; wr_col[3:0] = 4'h2; wr_char[7:0] = 8'h51;
        goto(841); chk("r_addr", lcd_data, 8'h82);
        goto(876); chk("r_data_ehi", 8'(lcd_e), 8'h01); chk("r_data", lcd_data, 8'h51);
        rst = 1'b1;
        #1;
        chk("mid_rst_e", 8'(lcd_e), 8'h00);
        chk("mid_rst_data", lcd_data, 8'h00);
        chk("mid_rst_rs", 8'(lcd_rs), 8'h00);
        chk("mid_rst_ready", 8'(ready), 8'h00);
        chk("mid_rst_done", 8'(done), 8'h00);
        req = 3'b000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        goto(71);  chk("re_func", lcd_data, 8'h3C);
        goto(276); chk("re_ready_276", 8'(ready), 8'h00);
        goto(277); chk("re_ready", 8'(ready), 8'h01);
        chk("re_pulses", 8'(e_rises), 8'd4);
        chk("no_done_after_rst", 8'(done_pulses), 8'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

Sequences the shared 16x2 character LCD bus and arbitrates it between the watch, alarm and stopwatch display writers. After reset it runs the LCD power-on command sequence. It then serves single-character write requests from three clients in round-robin order, turning each into a set-DDRAM-address command followed by a data write with fixed E-pulse and settle timing. It sits between the mode-specific display formatters and the LCD pins, replacing free-running per-mode data muxing.

## Interface
- PWR_WAIT, 70: idle cycles after reset before the first command
- E_HIGH, 2: cycles lcd_e is held high per bus transaction (≥1)
- CMD_WAIT, 30: settle cycles after a normal command
- CLR_WAIT, 100: settle cycles after Clear Display
- DATA_WAIT, 30: settle cycles after a data write
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req  in  3  per-client write request; bit i = client i
- wr_line  in  3  per-client LCD line (0 = top, 1 = bottom)
- wr_col  in  12  per-client column, 4 bits each, client i at [4i+3:4i]
- wr_char  in  24  per-client ASCII code, 8 bits each, client i at [8i+7:8i]
- done  out  3  one-cycle pulse to the served client when its write has completed
- ready  out  1  high once initialisation has finished
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  tied 0 (write only)
- lcd_data  out  8  LCD data bus

## Operation
- Reset values:
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, done=0, ready=0.
  - Round-robin pointer = client 0; state POWER_WAIT.
- State machine: POWER_WAIT → INIT_FUNC (8'h3C) → INIT_DISP (8'h0C) → INIT_CLR (8'h01) → INIT_ENTRY (8'h06) → IDLE ↔ ADDR → DATA → DONE → IDLE.
- Bus transaction, for every command and data write:
  - 1 setup cycle: lcd_rs and lcd_data valid, lcd_e=0.
  - E_HIGH cycles with lcd_e=1.
  - 1 hold cycle with lcd_e=0 and data unchanged.
  - Settle wait cycles.
  - lcd_rs and lcd_data hold their last values until the next setup cycle.
- ready goes high in the cycle IDLE is first entered and stays high until reset.
- Arbitration in IDLE:
  - Among asserted req bits, grant the first one at or after the pointer (cyclic 0→1→2→0).
  - Latch that client's line, col and char.
  - Set the pointer to (winner+1) mod 3.
  - If no req bit is set, stay in IDLE with the bus unchanged.
- ADDR issues command 8'h80|col for line 0, or 8'hC0|col for line 1, with rs=0 and CMD_WAIT settle.
- DATA issues the latched char with rs=1 and DATA_WAIT settle.
- DONE pulses done[winner] for one cycle, then returns to IDLE.
- Handshake:
  - A client holds req and its fields stable until it sees its done pulse, then may drop req or present the next character.
  - The block latches fields at arbitration, so a later change or req drop does not affect the transaction in flight, and done still pulses.
- Requests during POWER_WAIT or init are not served; they wait until IDLE.
- Async reset mid-transaction forces reset values at once and restarts POWER_WAIT. The interrupted write gets no done pulse.

## Timing
- Transaction length = E_HIGH+2+wait.
- Init with defaults:
  - POWER_WAIT occupies cycles 1..70 after reset release.
  - FUNC, DISP, CLR and ENTRY take 34, 34, 104 and 34 cycles.
  - ready rises at cycle 277.
- Write latency, with T = IDLE arbitration cycle and defaults:
  - ADDR occupies T+1..T+34; its setup is at T+1 and lcd_e is high at T+2..T+3.
  - DATA occupies T+35..T+68.
  - done at T+69; next arbitration at T+70.
- Sustained throughput: one character per 70 cycles (defaults).

## Structure
- Shared package lcd_pkg:
  - command constants LCD_FUNC_SET=8'h3C, LCD_DISP_ON=8'h0C, LCD_CLEAR=8'h01, LCD_ENTRY=8'h06, LCD_LINE0=8'h80, LCD_LINE1=8'hC0;
  - the state enum;
  - the client index constants WATCH=0, ALARM=1, STOPWATCH=2.
- Sub-module lcd_bus_cycle performs one transaction.
  - Inputs: start, rs, data, wait count.
  - Outputs: the lcd_* signals and a busy/finished flag.
  - The top level holds only the sequencing FSM and the arbiter.

## Test plan
- Reset release, no req: lcd_e pulses exactly 4 times, with data 3C, 0C, 01, 06 and rs=0; ready rises at cycle 277.
- After ready, client 1 requests line 1, col 5, char 8'h41: bus shows C5 (rs=0) then 41 (rs=1); done=3'b010 at T+69.
- All three req held continuously from IDLE, pointer=0: service order 0,1,2,0,1 with done pulses 70 cycles apart.
- Client 2 drops req and changes wr_char one cycle after arbitration: the originally latched char is written and done[2] still pulses.
- rst asserted during the lcd_e-high cycle of a DATA write: outputs go to reset values immediately, there is no done pulse, and the full init sequence reruns.
- req asserted at cycle 10 after reset: no lcd_e activity for that request before ready; its ADDR setup occurs the cycle after IDLE arbitration.
